lifo_stack_p: RTL and testbench
===============================

# lifo_stack_p

Parametrised LIFO for the Binary Maze solver: stores the move history (WIDTH-bit direction codes) during depth-first search and supports backtracking. Adds over the first-generation stack:
- configurable width and depth, using the full DEPTH entries;
- simultaneous push/pop (replace top);
- random-depth peek, for loop detection;
- sticky overflow/underflow error flags;
- a high-water mark for sizing runs.

## Interface
- WIDTH, 2, bits per entry
- DEPTH, 256, number of entries; any value ≥ 2
- AW, $clog2(DEPTH), index width (derived; not overridden)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- init  in  1  synchronous clear of contents, count and high-water mark (error flags kept)
- push  in  1  write data_in on top
- pop  in  1  remove top entry
- data_in  in  WIDTH  entry to push
- err_clear  in  1  synchronous clear of overflow/underflow
- peek_idx  in  AW  depth below top to read (0 = top)
- data_out  out  WIDTH  top entry; 0 when empty
- peek_data  out  WIDTH  entry at depth peek_idx; 0 when peek_valid=0
- peek_valid  out  1  peek_idx < count
- count  out  AW+1  current occupancy, 0..DEPTH
- high_water  out  AW+1  maximum count since reset/init
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push attempted while full, without pop
- underflow  out  1  sticky: pop attempted while empty, without push

## Operation
- Storage is DEPTH×WIDTH registers; entry i (0 = bottom) is valid for i < count. Invalid entries are written to 0, never X/Z.
- Per-cycle priority (highest first):
  - reset_n low: all state 0, asynchronously.
  - init: count, high_water and all entries set to 0; overflow/underflow unchanged; push/pop ignored.
  - push & pop, count > 0: stack[count-1] ← data_in; count unchanged (replace top).
  - push & pop, count == 0: behaves as push only; no underflow.
  - push only, not full: stack[count] ← data_in; count+1.
  - push only, full: no change to storage or count; overflow ← 1.
  - pop only, not empty: stack[count-1] ← 0; count-1.
  - pop only, empty: no change; underflow ← 1.
- err_clear clears overflow/underflow. If an error event occurs in the same cycle, the flag is set (set wins).
- high_water ← max(high_water, next count) every cycle; it saturates at DEPTH.
- Index arithmetic is done in AW+1 bits. There is no wrap-around: count never exceeds DEPTH or goes below 0.

## Timing
- All state updates on the rising edge of clock; reset acts asynchronously on assertion and is released synchronously in the design context.
- data_out, peek_data, peek_valid, full and empty are combinational from registered state. A push at edge N is visible on data_out immediately after edge N, i.e. zero-cycle read latency after the write edge.
- peek_data = stack[count-1-peek_idx]. It changes combinationally with peek_idx, within the same cycle.
- After reset:
  - count = 0, high_water = 0;
  - empty = 1, full = 0;
  - data_out = 0, peek_valid = 0, peek_data = 0;
  - overflow = 0, underflow = 0.
- One operation per cycle; no handshake or backpressure. The requester must check full/empty, or monitor the error flags.

## Test plan
- Reset/fill: with DEPTH=4, push 1,2,3,0 on consecutive cycles → count=4, full=1, data_out=0, high_water=4. Push again → overflow=1, contents unchanged.
- Drain/underflow: pop four times → data_out sequence 3,2,1 then 0, and empty=1. Pop again → underflow=1, count stays 0. err_clear → flag drops next cycle.
- Replace top: stack holds 1,2; push=pop=1 with data_in=3 → count=2, data_out=3, peek_idx=1 gives 1. The same operation on an empty stack → count=1, data_out=3, underflow=0.
- Peek: stack holds 0,1,2,3 (bottom→top). peek_idx = 0,1,2,3 → peek_data = 3,2,1,0 with peek_valid=1. peek_idx ≥ 4 (DEPTH=8) → peek_valid=0, peek_data=0.
- init vs errors: set overflow, then pulse init with push=1 → count=0, high_water=0, overflow still 1, nothing pushed.
- Async reset mid-operation: assert reset_n low between edges while count=3 → count=0 and data_out=0 immediately, before the next edge. Repeat with WIDTH=5, DEPTH=37 for parameter coverage.

Source files
------------

// File: rtl/lifo_stack_p.sv
// lifo_stack_p: parametrised LIFO holding the maze solver's move history.
// Supports push, pop, replace-top (push+pop), random-depth peek, sticky
// overflow/underflow flags and a high-water mark.
//
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   init                sync clear of contents, count, high_water (flags kept)
//   push, pop, data_in  stack operations; push+pop replaces the top entry
//   err_clear           sync clear of overflow/underflow (a same-cycle set wins)
//   peek_idx            depth below top to read (0 = top)
//   data_out            top entry, 0 when empty (combinational)
//   peek_data/valid     entry at peek_idx, 0 when invalid (combinational)
//   count, high_water   occupancy and its maximum since reset/init (registered)
//   full, empty         occupancy flags (combinational)
//   overflow, underflow sticky error flags (registered)
module lifo_stack_p #(
    parameter  int unsigned WIDTH = 2,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             init,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clear,
    input  logic [AW-1:0]    peek_idx,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    high_water,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    high_water_q, high_water_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    peek_pos;

    // Index arithmetic is done in count width, then narrowed to an array index.
    assign top_idx  = AW'(count_q - CW'(1));
    assign push_idx = AW'(count_q);
    assign peek_pos = AW'(count_q - CW'(1) - CW'(peek_idx));

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign data_out   = empty ? '0 : stack_q[top_idx];
    assign peek_valid = (CW'(peek_idx) < count_q);
    assign peek_data  = peek_valid ? stack_q[peek_pos] : '0;

    assign count      = count_q;
    assign high_water = high_water_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    // Next-state: init dominates, then replace-top, push, pop.
    always_comb begin
        stack_d     = stack_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~err_clear;
        underflow_d = underflow_q & ~err_clear;

        if (init) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_d[i] = '0;
            end
            count_d = '0;
        end else if (push && pop) begin
            if (empty) begin
                stack_d[0] = data_in;
                count_d    = CW'(1);
            end else begin
                stack_d[top_idx] = data_in;
            end
        end else if (push) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                stack_d[push_idx] = data_in;
                count_d           = count_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                // Vacated entries are zeroed so invalid slots never hold stale data.
                stack_d[top_idx] = '0;
                count_d          = count_q - CW'(1);
            end
        end

        // count_d never exceeds DEPTH, so the max saturates on its own.
        if (init) begin
            high_water_d = '0;
        end else if (count_d > high_water_q) begin
            high_water_d = count_d;
        end else begin
            high_water_d = high_water_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            count_q      <= '0;
            high_water_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            stack_q      <= stack_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_lifo_stack_p.sv
// Bench for lifo_stack_p: three instances (W2/D4, W2/D8, W5/D37) share one
// set of stimulus signals, gated by a target select.
module tb_lifo_stack_p;

    typedef struct {
        int t;
        bit ini, pu, po, ec;
        int din, pidx;
        int c, dout, hw;
        bit fl, em, ov, ud, pv;
        int pd;
    } vec_t;

    logic       clock;
    logic       reset_n;
    int         tgt;
    logic       ini_s, pu_s, po_s, ec_s;
    logic [4:0] din_s;
    logic [5:0] pidx_s;
    logic [2:0] ini_g, pu_g, po_g, ec_g;

    logic [1:0] dout_a, pd_a;
    logic [2:0] cnt_a, hw_a;
    logic       pv_a, full_a, empty_a, ovf_a, udf_a;
    logic [1:0] dout_b, pd_b;
    logic [3:0] cnt_b, hw_b;
    logic       pv_b, full_b, empty_b, ovf_b, udf_b;
    logic [4:0] dout_c, pd_c;
    logic [6:0] cnt_c, hw_c;
    logic       pv_c, full_c, empty_c, ovf_c, udf_c;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ini_g[k] = ini_s && (tgt == k);
            pu_g[k]  = pu_s  && (tgt == k);
            po_g[k]  = po_s  && (tgt == k);
            ec_g[k]  = ec_s  && (tgt == k);
        end
    end

    lifo_stack_p #(.WIDTH(2), .DEPTH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .init(ini_g[0]), .push(pu_g[0]),
        .pop(po_g[0]), .data_in(din_s[1:0]), .err_clear(ec_g[0]),
        .peek_idx(pidx_s[1:0]), .data_out(dout_a), .peek_data(pd_a),
        .peek_valid(pv_a), .count(cnt_a), .high_water(hw_a), .full(full_a),
        .empty(empty_a), .overflow(ovf_a), .underflow(udf_a));

    lifo_stack_p #(.WIDTH(2), .DEPTH(8)) u_b (
        .clock(clock), .reset_n(reset_n), .init(ini_g[1]), .push(pu_g[1]),
        .pop(po_g[1]), .data_in(din_s[1:0]), .err_clear(ec_g[1]),
        .peek_idx(pidx_s[2:0]), .data_out(dout_b), .peek_data(pd_b),
        .peek_valid(pv_b), .count(cnt_b), .high_water(hw_b), .full(full_b),
        .empty(empty_b), .overflow(ovf_b), .underflow(udf_b));

    lifo_stack_p #(.WIDTH(5), .DEPTH(37)) u_c (
        .clock(clock), .reset_n(reset_n), .init(ini_g[2]), .push(pu_g[2]),
        .pop(po_g[2]), .data_in(din_s), .err_clear(ec_g[2]),
        .peek_idx(pidx_s), .data_out(dout_c), .peek_data(pd_c),
        .peek_valid(pv_c), .count(cnt_c), .high_water(hw_c), .full(full_c),
        .empty(empty_c), .overflow(ovf_c), .underflow(udf_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input int t, input bit ini, pu, po, ec,
                                input int din, pidx, input int c, dout, hw,
                                input bit fl, em, ov, ud, pv, input int pd);
        vec_t v;
        v.t = t; v.ini = ini; v.pu = pu; v.po = po; v.ec = ec;
        v.din = din; v.pidx = pidx; v.c = c; v.dout = dout; v.hw = hw;
        v.fl = fl; v.em = em; v.ov = ov; v.ud = ud; v.pv = pv; v.pd = pd;
        return v;
    endfunction

    task automatic cmp(input string nm, input int dut, input int act, input int expv);
        if (act != expv) begin
            n_err++;
            $display("FAIL %s dut%0d vector %0d: got %0d, expected %0d",
                     nm, dut, n_vec, act, expv);
        end
    endtask

    task automatic check_now(input vec_t e);
        int c, d, h, pd;
        bit fl, em, ov, ud, pv;
        case (e.t)
            0: begin
                c = int'(cnt_a); d = int'(dout_a); h = int'(hw_a); pd = int'(pd_a);
                fl = full_a; em = empty_a; ov = ovf_a; ud = udf_a; pv = pv_a;
            end
            1: begin
                c = int'(cnt_b); d = int'(dout_b); h = int'(hw_b); pd = int'(pd_b);
                fl = full_b; em = empty_b; ov = ovf_b; ud = udf_b; pv = pv_b;
            end
            default: begin
                c = int'(cnt_c); d = int'(dout_c); h = int'(hw_c); pd = int'(pd_c);
                fl = full_c; em = empty_c; ov = ovf_c; ud = udf_c; pv = pv_c;
            end
        endcase
        n_vec++;
        cmp("count",      e.t, c,       e.c);
        cmp("data_out",   e.t, d,       e.dout);
        cmp("high_water", e.t, h,       e.hw);
        cmp("full",       e.t, int'(fl), int'(e.fl));
        cmp("empty",      e.t, int'(em), int'(e.em));
        cmp("overflow",   e.t, int'(ov), int'(e.ov));
        cmp("underflow",  e.t, int'(ud), int'(e.ud));
        cmp("peek_valid", e.t, int'(pv), int'(e.pv));
        cmp("peek_data",  e.t, pd,      e.pd);
    endtask

    // Drive one cycle, queue its expectation, check just after the edge.
    task automatic step(input vec_t v);
        tgt    = v.t;
        ini_s  = v.ini;
        pu_s   = v.pu;
        po_s   = v.po;
        ec_s   = v.ec;
        din_s  = 5'(v.din);
        pidx_s = 6'(v.pidx);
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        check_now(exp_q.pop_front());
    endtask

    task automatic idle_inputs();
        ini_s = 1'b0; pu_s = 1'b0; po_s = 1'b0; ec_s = 1'b0;
        din_s = '0; pidx_s = '0;
    endtask

    initial begin
        int val, last;
        //         t  in pu po ec din pix  cnt dout hw  fl em ov ud pv pd
        // DUT A (W2/D4): fill, overflow, drain, underflow, clear
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,  1, 1, 1,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0,  2, 2, 2,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1,  3, 3, 3,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3,  4, 0, 4,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 2,  4, 0, 4,  1, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  3, 3, 4,  0, 0, 1, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  2, 2, 4,  0, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 4,  0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 4,  0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 4,  0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 4,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 4,  0, 1, 0, 0, 0, 0));
        // DUT A: replace top, on a non-empty and an empty stack
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,  1, 1, 4,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0,  2, 2, 4,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 3, 1,  2, 3, 4,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 4,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 4,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 3, 0,  1, 3, 4,  0, 0, 0, 0, 1, 3));
        // DUT A: replace top when full, overflow, then init keeps flags
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0,  2, 2, 4,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,  3, 1, 4,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  4, 0, 4,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0,  4, 1, 4,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 0,  4, 1, 4,  1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0,  0, 0, 0,  0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 0, 0, 0));
        // err_clear with an underflow in the same cycle: set wins
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0, 0, 0,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        // DUT B (W2/D8): peek at every depth and beyond count
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,  1, 0, 1,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0,  2, 1, 2,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 0,  3, 2, 3,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1, 0, 0, 3, 0,  4, 3, 4,  0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,  4, 3, 4,  0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2,  4, 3, 4,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3,  4, 3, 4,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4,  4, 3, 4,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 7,  4, 3, 4,  0, 0, 0, 0, 0, 0));
        // DUT C (W5/D37): wide entries
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 1, 0, 0, 31, 0, 1, 31, 1, 0, 0, 0, 0, 1, 31));
        tbl.push_back(mk(2, 0, 1, 0, 0, 17, 1, 2, 17, 2, 0, 0, 0, 0, 1, 31));
        tbl.push_back(mk(2, 0, 1, 0, 0, 5, 2,  3, 5, 3,  0, 0, 0, 0, 1, 31));

        tgt = 0;
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Peek follows peek_idx within the cycle, no clock edge needed.
        tgt = 1;
        idle_inputs();
        pidx_s = 6'd1;
        #1;
        check_now(mk(1, 0, 0, 0, 0, 0, 1,  4, 3, 4,  0, 0, 0, 0, 1, 2));
        pidx_s = 6'd3;
        #1;
        check_now(mk(1, 0, 0, 0, 0, 0, 3,  4, 3, 4,  0, 0, 0, 0, 1, 0));

        // Fill the non-power-of-two stack to DEPTH=37, then overflow.
        last = 5;
        for (int k = 4; k <= 37; k++) begin
            val = (k * 7) % 32;
            step(mk(2, 0, 1, 0, 0, val, 0, k, val, k, k == 37, 0, 0, 0, 1, val));
            last = val;
        end
        step(mk(2, 0, 1, 0, 0, 9, 0,  37, last, 37, 1, 0, 1, 0, 1, last));
        step(mk(2, 0, 0, 0, 0, 0, 36, 37, last, 37, 1, 0, 1, 0, 1, 31));
        step(mk(2, 0, 0, 0, 0, 0, 37, 37, last, 37, 1, 0, 1, 0, 0, 0));

        // Async reset between edges while A holds three entries.
        step(mk(0, 0, 1, 0, 0, 1, 0,  1, 1, 1,  0, 0, 0, 0, 1, 1));
        step(mk(0, 0, 1, 0, 0, 2, 0,  2, 2, 2,  0, 0, 0, 0, 1, 2));
        step(mk(0, 0, 1, 0, 0, 3, 0,  3, 3, 3,  0, 0, 0, 0, 1, 3));
        idle_inputs();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_now(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        check_now(mk(2, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0));
        step(mk(2, 0, 1, 0, 0, 21, 0, 1, 21, 1, 0, 0, 0, 0, 1, 21));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
